// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: waits for all PLL locks, holds reset, then releases
// the stage resets in ascending order with an optional ready gate on stage 1.
module reset_sequencer #(
  parameter int NUM_LOCKS   = 2,
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 65536,
  parameter int STAGE_GAP   = 16,
  parameter int RDY_GATE    = 1,
  parameter int RDY_TIMEOUT = 4096,
  parameter int CNT_W       = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [NUM_LOCKS-1:0]  lock_in,
  input  logic                  rdy_in,
  input  logic                  soft_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  done,
  output logic                  rdy_timeout,
  output logic [CNT_W-1:0]      relock_cnt,
  output logic [2:0]            state
);

  localparam int MAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_T = (MAX_A > RDY_TIMEOUT) ? MAX_A : RDY_TIMEOUT;
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int KW    = $clog2(NUM_STAGES);

  localparam logic [TW-1:0] HOLD_TC = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_TC  = TW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] RDY_TC  = TW'(RDY_TIMEOUT - 1);
  localparam logic [KW-1:0] LAST_K  = KW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD      = 3'd1,
    S_REL0      = 3'd2,
    S_WAIT_RDY  = 3'd3,
    S_REL       = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  logic [NUM_LOCKS-1:0]  r_lock_meta, r_lock_sync;
  logic                  r_lock_ok, r_rdy_meta, r_rdy_sync;
  state_t                r_state, w_state;
  logic [TW-1:0]         r_cnt, w_cnt, w_cnt_inc;
  logic [KW-1:0]         r_k, w_k;
  logic [NUM_STAGES-1:0] r_rst, w_rst;
  logic                  r_done, w_done, r_tmo, w_tmo;
  logic [CNT_W-1:0]      r_relock, w_relock;

  // Lock lines are qualified through two sync flops and a registered AND.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lock_meta <= '0;
      r_lock_sync <= '0;
      r_lock_ok   <= 1'b0;
      r_rdy_meta  <= 1'b0;
      r_rdy_sync  <= 1'b0;
    end else begin
      r_lock_meta <= lock_in;
      r_lock_sync <= r_lock_meta;
      r_lock_ok   <= &r_lock_sync;
      r_rdy_meta  <= rdy_in;
      r_rdy_sync  <= r_rdy_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= S_WAIT_LOCK;
      r_cnt    <= '0;
      r_k      <= '0;
      r_rst    <= '1;
      r_done   <= 1'b0;
      r_tmo    <= 1'b0;
      r_relock <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_k      <= w_k;
      r_rst    <= w_rst;
      r_done   <= w_done;
      r_tmo    <= w_tmo;
      r_relock <= w_relock;
    end
  end

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + TW'(1);

  // Lock loss outranks soft reset; both are ignored while already waiting for lock.
  always_comb begin
    w_state  = r_state;
    w_cnt    = w_cnt_inc;
    w_k      = r_k;
    w_rst    = r_rst;
    w_done   = r_done;
    w_tmo    = r_tmo;
    w_relock = r_relock;
    if ((r_state != S_WAIT_LOCK) && !r_lock_ok) begin
      w_state  = S_WAIT_LOCK;
      w_rst    = '1;
      w_done   = 1'b0;
      w_cnt    = '0;
      w_relock = (r_relock == '1) ? r_relock : r_relock + CNT_W'(1);
    end else if ((r_state != S_WAIT_LOCK) && soft_rst) begin
      w_state = S_HOLD;
      w_rst   = '1;
      w_done  = 1'b0;
      w_cnt   = '0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          w_rst  = '1;
          w_done = 1'b0;
          w_cnt  = '0;
          if (r_lock_ok) w_state = S_HOLD;
          else           w_state = S_WAIT_LOCK;
        end
        S_HOLD: begin
          if (r_cnt == HOLD_TC) begin
            w_rst[0] = 1'b0;
            w_cnt    = '0;
            w_k      = KW'(1);
            if (RDY_GATE != 0) w_state = S_WAIT_RDY;
            else               w_state = S_REL;
          end else begin
            w_state = S_HOLD;
          end
        end
        S_WAIT_RDY: begin
          if (r_rdy_sync) begin
            w_state = S_REL;
            w_cnt   = '0;
          end else if (r_cnt == RDY_TC) begin
            w_state = S_REL;
            w_cnt   = '0;
            w_tmo   = 1'b1;
          end else begin
            w_state = S_WAIT_RDY;
          end
        end
        S_REL: begin
          if (r_cnt == GAP_TC) begin
            w_rst = r_rst & ~(NUM_STAGES'(1) << r_k);
            w_cnt = '0;
            if (r_k == LAST_K) begin
              w_done  = 1'b1;
              w_state = S_DONE;
            end else begin
              w_k     = r_k + KW'(1);
              w_state = S_REL;
            end
          end else begin
            w_state = S_REL;
          end
        end
        S_DONE: begin
          w_rst   = '0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end
        default: begin
          w_state = S_WAIT_LOCK;
          w_rst   = '1;
          w_done  = 1'b0;
          w_cnt   = '0;
        end
      endcase
    end
  end

  assign rst_out     = r_rst;
  assign done        = r_done;
  assign rdy_timeout = r_tmo;
  assign relock_cnt  = r_relock;
  assign state       = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations share one stimulus stream and are
// compared each cycle against a release-time model, plus directed timing checks.
module tb_reset_sequencer;

  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int NS   = 3;
  localparam int ND   = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [1:0]    lock_in = 2'b00;
  logic          rdy_in = 1'b0;
  logic          soft_rst = 1'b0;
  logic [NS-1:0] rst_out [ND];
  logic          done [ND];
  logic          rdy_timeout [ND];
  logic [7:0]    relock_cnt [ND];
  logic [2:0]    state [ND];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  int m_gate [ND] = '{0, 1, 1};
  int m_tmo  [ND] = '{4096, 4096, 8};
  int m_mode [ND];
  int m_t0   [ND];
  int m_rs   [ND];
  int m_to   [ND];
  int m_rc   [ND];
  bit lk_d [3];
  bit rd_d [2];

  int f_hold [ND], f_r0 [ND], f_r1 [ND], f_r2 [ND], f_done [ND], f_to [ND], f_rel [ND];
  int t0, d0;

  always #5 sys_clk = ~sys_clk;

  reset_sequencer #(.NUM_LOCKS(2), .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
                    .RDY_GATE(0), .RDY_TIMEOUT(4096), .CNT_W(8)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lock_in(lock_in), .rdy_in(rdy_in),
    .soft_rst(soft_rst), .rst_out(rst_out[0]), .done(done[0]), .rdy_timeout(rdy_timeout[0]),
    .relock_cnt(relock_cnt[0]), .state(state[0]));

  reset_sequencer #(.NUM_LOCKS(2), .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
                    .RDY_GATE(1), .RDY_TIMEOUT(4096), .CNT_W(8)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lock_in(lock_in), .rdy_in(rdy_in),
    .soft_rst(soft_rst), .rst_out(rst_out[1]), .done(done[1]), .rdy_timeout(rdy_timeout[1]),
    .relock_cnt(relock_cnt[1]), .state(state[1]));

  reset_sequencer #(.NUM_LOCKS(2), .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
                    .RDY_GATE(1), .RDY_TIMEOUT(8), .CNT_W(8)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lock_in(lock_in), .rdy_in(rdy_in),
    .soft_rst(soft_rst), .rst_out(rst_out[2]), .done(done[2]), .rdy_timeout(rdy_timeout[2]),
    .relock_cnt(relock_cnt[2]), .state(state[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_mode[i] = 0; m_t0[i] = 0; m_rs[i] = -1; m_to[i] = 0; m_rc[i] = 0;
    end
    for (int j = 0; j < 3; j++) lk_d[j] = 1'b0;
    rd_d[0] = 1'b0; rd_d[1] = 1'b0;
  endtask

  // Model: sequencing is described by the HOLD entry time and the REL start time.
  task automatic model_step();
    bit l_ok, r_ok;
    l_ok = lk_d[2];
    r_ok = rd_d[1];
    lk_d[2] = lk_d[1]; lk_d[1] = lk_d[0]; lk_d[0] = &lock_in;
    rd_d[1] = rd_d[0]; rd_d[0] = rdy_in;
    for (int i = 0; i < ND; i++) begin
      if (m_mode[i] == 0) begin
        if (l_ok) begin
          m_mode[i] = 1; m_t0[i] = cyc;
          m_rs[i] = (m_gate[i] != 0) ? -1 : cyc + HOLD;
        end
      end else if (!l_ok) begin
        m_mode[i] = 0;
        if (m_rc[i] < 255) m_rc[i]++;
      end else if (soft_rst) begin
        m_t0[i] = cyc;
        m_rs[i] = (m_gate[i] != 0) ? -1 : cyc + HOLD;
      end else if (m_gate[i] != 0 && m_rs[i] < 0 && (cyc - m_t0[i]) > HOLD) begin
        if (r_ok) m_rs[i] = cyc;
        else if (cyc - m_t0[i] - HOLD == m_tmo[i]) begin
          m_to[i] = 1; m_rs[i] = cyc;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < ND; i++) begin
      logic [NS-1:0] er;
      logic          ed;
      logic [2:0]    es;
      er = '1; ed = 1'b0; es = 3'd0;
      if (m_mode[i] != 0) begin
        if (cyc - m_t0[i] < HOLD) es = 3'd1;
        else if (m_rs[i] < 0) begin
          er = 3'b110; es = 3'd3;
        end else begin
          er[0] = 1'b0;
          for (int k = 1; k < NS; k++) er[k] = (cyc < m_rs[i] + k * GAP);
          ed = (cyc >= m_rs[i] + (NS - 1) * GAP);
          es = ed ? 3'd5 : 3'd4;
        end
      end
      chk($sformatf("d%0d_rst_out", i), rst_out[i], er);
      chk($sformatf("d%0d_done", i), done[i], ed);
      chk($sformatf("d%0d_state", i), state[i], es);
      chk($sformatf("d%0d_rdy_timeout", i), rdy_timeout[i], m_to[i]);
      chk($sformatf("d%0d_relock_cnt", i), relock_cnt[i], m_rc[i]);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    cyc++;
    if (sys_rst_n) model_step();
    #1;
    check_all();
  endtask

  task automatic wait_state(input int i, input logic [2:0] s, input int lim);
    int k;
    k = 0;
    while (state[i] !== s && k < lim) begin
      tick();
      k++;
    end
    chk($sformatf("wait_d%0d_state%0d", i, s), state[i], s);
  endtask

  task automatic drop_lock1();
    lock_in = 2'b01;
    tick();
    lock_in = 2'b11;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    tick();

    // Sequence timing from lock: three configurations in parallel.
    for (int i = 0; i < ND; i++) begin
      f_hold[i] = -1; f_r0[i] = -1; f_r1[i] = -1; f_r2[i] = -1;
      f_done[i] = -1; f_to[i] = -1; f_rel[i] = -1;
    end
    lock_in = 2'b11;
    t0 = cyc + 1;
    for (int n = 0; n < 60; n++) begin
      tick();
      for (int i = 0; i < ND; i++) begin
        if (f_hold[i] < 0 && state[i] == 3'd1) f_hold[i] = cyc;
        if (f_r0[i] < 0 && rst_out[i][0] == 1'b0) f_r0[i] = cyc;
        if (f_r1[i] < 0 && rst_out[i][1] == 1'b0) f_r1[i] = cyc;
        if (f_r2[i] < 0 && rst_out[i][2] == 1'b0) f_r2[i] = cyc;
        if (f_done[i] < 0 && done[i] == 1'b1) f_done[i] = cyc;
        if (f_to[i] < 0 && rdy_timeout[i] == 1'b1) f_to[i] = cyc;
        if (f_rel[i] < 0 && state[i] == 3'd4) f_rel[i] = cyc;
      end
      if (f_r0[0] >= 0 && cyc == f_r0[0] + 10) rdy_in = 1'b1;
    end
    chk("t1_hold_entry", f_hold[0] - t0, 3);
    chk("t1_rst0_fall", f_r0[0] - t0, 19);
    chk("t1_rst1_fall", f_r1[0] - t0, 23);
    chk("t1_rst2_fall", f_r2[0] - t0, 27);
    chk("t1_done_rise", f_done[0] - t0, 27);
    chk("t2_rdy_exit", f_rel[1] - f_r0[1], 13);
    chk("t2_rst1_gap", f_r1[1] - f_rel[1], GAP);
    chk("t2_no_timeout", rdy_timeout[1], 0);
    chk("t3_timeout_at", f_to[2] - f_r0[2], 8);
    chk("t3_rel_at", f_rel[2] - f_r0[2], 8);
    chk("t3_done", done[2], 1);

    // Timeout flag is sticky across a software restart.
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("t3_sticky", rdy_timeout[2], 1);
    chk("t3_soft_hold", state[2], 3'd1);
    wait_state(2, 3'd5, 60);

    // Single-cycle lock glitch in DONE, then full HOLD re-run.
    wait_state(0, 3'd5, 60);
    drop_lock1();
    d0 = cyc;
    tick();
    tick();
    chk("t4_still_done", done[0], 1);
    tick();
    chk("t4_rst_all", rst_out[0], 3'b111);
    chk("t4_done_low", done[0], 0);
    chk("t4_relock1", relock_cnt[0], 1);
    f_r0[0] = -1;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (f_r0[0] < 0 && rst_out[0][0] == 1'b0) f_r0[0] = cyc;
    end
    chk("t4_hold_rerun", f_r0[0] - d0, 20);
    for (int r = 0; r < 300; r++) begin
      drop_lock1();
      repeat (5) tick();
    end
    for (int i = 0; i < ND; i++) chk($sformatf("t4_sat_d%0d", i), relock_cnt[i], 255);

    // Asynchronous reset in the middle of REL.
    wait_state(0, 3'd4, 40);
    sys_rst_n = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("t6_rst_d%0d", i), rst_out[i], 3'b111);
      chk($sformatf("t6_state_d%0d", i), state[i], 0);
      chk($sformatf("t6_relock_d%0d", i), relock_cnt[i], 0);
      chk($sformatf("t6_tmo_d%0d", i), rdy_timeout[i], 0);
    end
    model_reset();
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("t6_restart_wl", state[0], 0);

    // Lock loss and soft reset on the same FSM cycle during REL.
    wait_state(0, 3'd4, 40);
    drop_lock1();
    tick();
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("t5_lock_wins", state[0], 0);
    chk("t5_relock", relock_cnt[0], 1);
    wait_state(0, 3'd5, 60);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("t5_soft_hold", state[0], 3'd1);
    chk("t5_relock_kept", relock_cnt[0], 1);

    // Random glitches, soft resets and ready toggles.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      lock_in = 2'b11;
      if (r < 2) lock_in = 2'($urandom_range(0, 2));
      soft_rst = (r >= 2 && r < 4);
      if ($urandom_range(0, 19) == 0) rdy_in = ~rdy_in;
      tick();
    end
    soft_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
